// File: rtl/display_pkg.sv
// Shared constants and helpers for the digit scan path.
package display_pkg;

  // Default width of one digit value.
  localparam int DIGIT_W_DEFAULT = 4;
  // Widest bank digit_slice can address.
  localparam int MAX_DIGITS = 16;

  // Digit selects are active low; an idle select bit sits at AN_OFF.
  localparam logic AN_OFF = 1'b1;

  typedef logic [DIGIT_W_DEFAULT-1:0] digit_t;

  // Pull digit k out of a packed digit bus (digit k at [k*W +: W]).
  function automatic digit_t digit_slice(
    input logic [MAX_DIGITS*DIGIT_W_DEFAULT-1:0] bus,
    input int unsigned                           k
  );
    return bus[k*DIGIT_W_DEFAULT +: DIGIT_W_DEFAULT];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Wrapping 0..DIV-1 counter that advances when enabled and flags its last count.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick on the enabled terminal count; wrap back to zero on it.
  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (en_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_manager.sv
// Digit bank with hold, plus a rotating active-low scan with blink and blank.
module display_scan_manager
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int DIGIT_W     = DIGIT_W_DEFAULT,
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_SCANS = 250
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          update_i,
  input  logic                          hold_i,
  input  logic                          blank_i,
  input  logic [N_DIGITS-1:0]           blink_mask_i,
  input  logic [N_DIGITS*DIGIT_W-1:0]   digits_i,
  output logic [N_DIGITS*DIGIT_W-1:0]   digits_o,
  output logic [DIGIT_W-1:0]            digit_o,
  output logic [N_DIGITS-1:0]           an_o,
  output logic [$clog2(N_DIGITS)-1:0]   scan_idx_o,
  output logic                          display_en_o
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [N_DIGITS*DIGIT_W-1:0] bank_q, bank_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        en_q, en_d;
  logic [N_DIGITS-1:0]         an_q, an_d;
  logic                        scan_tick, rot_tick, blink_tick;

  tick_divider #(.DIV(SCAN_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .tick_o (scan_tick)
  );

  tick_divider #(.DIV(BLINK_SCANS)) u_blink_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (rot_tick),
    .tick_o (blink_tick)
  );

  // Bank load; hold freezes it regardless of update.
  always_comb begin
    bank_d = bank_q;
    if (update_i && !hold_i) bank_d = digits_i;
  end

  // Scan index with explicit wrap so non power-of-two digit counts work.
  always_comb begin
    rot_tick = scan_tick && (idx_q == LAST_IDX);
    idx_d    = idx_q;
    if (scan_tick) idx_d = rot_tick ? '0 : idx_q + 1'b1;
    en_d     = en_q ^ blink_tick;
  end

  // Select from next-state index/phase so an_o moves on the same edge as scan_idx.
  always_comb begin
    an_d = {N_DIGITS{AN_OFF}};
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((IDX_W'(k) == idx_d) && !blank_i && (!blink_mask_i[k] || en_d))
        an_d[k] = ~AN_OFF;
    end
  end

  // Selected digit, purely from registered state.
  always_comb begin
    digit_o = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) digit_o = bank_q[k*DIGIT_W +: DIGIT_W];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      idx_q  <= '0;
      en_q   <= 1'b0;
      an_q   <= {N_DIGITS{AN_OFF}};
    end else begin
      bank_q <= bank_d;
      idx_q  <= idx_d;
      en_q   <= en_d;
      an_q   <= an_d;
    end
  end

  assign digits_o     = bank_q;
  assign an_o         = an_q;
  assign scan_idx_o   = idx_q;
  assign display_en_o = en_q;

endmodule

// File: tb/tb_display_scan_manager.sv
// Directed bench: stimulus queues expected values per cycle, a monitor compares them.
module tb_display_scan_manager;
  import display_pkg::*;

  localparam int R = 3;   // cycle count at which reset is first released

  localparam int S_AN = 0, S_DIG = 1, S_DIGS = 2, S_IDX = 3, S_EN = 4, S_IDX2 = 5, S_AN2 = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update = 1'b0, hold = 1'b0, blank = 1'b0;
  logic [3:0]  mask = '0;
  logic [15:0] din = '0;
  logic [15:0] digits_o;
  logic [3:0]  digit_o, an_o;
  logic [1:0]  idx_o;
  logic        en_o;

  logic [2:0]  mask2 = '0;
  logic [11:0] din2 = 12'h321;
  logic [11:0] digits2_o;
  logic [3:0]  digit2_o;
  logic [2:0]  an2_o;
  logic [1:0]  idx2_o;
  logic        en2_o;

  display_scan_manager #(.N_DIGITS(4), .DIGIT_W(4), .SCAN_DIV(4), .BLINK_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .update_i(update), .hold_i(hold), .blank_i(blank),
    .blink_mask_i(mask), .digits_i(din), .digits_o(digits_o), .digit_o(digit_o),
    .an_o(an_o), .scan_idx_o(idx_o), .display_en_o(en_o)
  );

  display_scan_manager #(.N_DIGITS(3), .DIGIT_W(4), .SCAN_DIV(1), .BLINK_SCANS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .update_i(update), .hold_i(hold), .blank_i(blank),
    .blink_mask_i(mask2), .digits_i(din2), .digits_o(digits2_o), .digit_o(digit2_o),
    .an_o(an2_o), .scan_idx_o(idx2_o), .display_en_o(en2_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int sel; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_AN:    return 32'(an_o);
      S_DIG:   return 32'(digit_o);
      S_DIGS:  return 32'(digits_o);
      S_IDX:   return 32'(idx_o);
      S_EN:    return 32'(en_o);
      S_IDX2:  return 32'(idx2_o);
      default: return 32'(an2_o);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_AN:    return "an_o";
      S_DIG:   return "digit_o";
      S_DIGS:  return "digits_o";
      S_IDX:   return "scan_idx_o";
      S_EN:    return "display_en_o";
      S_IDX2:  return "n3_scan_idx_o";
      default: return "n3_an_o";
    endcase
  endfunction

  // Keep the scoreboard ordered by cycle.
  task automatic push(input int c, input int sel, input logic [31:0] v);
    exp_t e;
    int pos;
    e.cyc = c; e.sel = sel; e.val = v;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > c) pos--;
    sb.insert(pos, e);
  endtask

  task automatic wait_to(input int t);
    if (cyc > t) $fatal(1, "FAIL wait_to cycle %0d already passed at %0d", t, cyc);
    while (cyc != t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare everything due this cycle, away from the active edge.
  exp_t cur;
  logic [31:0] got;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      got = sample(cur.sel);
      checks = checks + 1;
      if (cur.cyc != cyc || got !== cur.val) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d got=%h exp=%h", sel_name(cur.sel), cur.cyc, got, cur.val);
      end
    end
  end

  logic [3:0] an_rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] dig_rot[4] = '{4'h1, 4'h2, 4'h3, 4'h4};

  initial begin
    int r2;
    logic [63:0] abcd;
    abcd = 64'h0000_0000_0000_ABCD;

    // Reset state.
    push(1, S_AN, 4'hF); push(1, S_DIG, 0); push(1, S_DIGS, 0);
    push(1, S_IDX, 0);   push(1, S_EN, 0);  push(1, S_IDX2, 0);

    wait_to(R);
    rst_n = 1'b1;
    push(R, S_AN, 4'hF);
    push(R+1, S_AN, 4'b1110); push(R+1, S_IDX, 0);
    // Three-digit, divide-by-one instance: index steps every cycle, never 3.
    push(R+1, S_IDX2, 1); push(R+2, S_IDX2, 2); push(R+3, S_IDX2, 0);
    push(R+4, S_IDX2, 1); push(R+5, S_IDX2, 2); push(R+6, S_IDX2, 0);
    push(R+1, S_AN2, 3'b101); push(R+2, S_AN2, 3'b011); push(R+3, S_AN2, 3'b110);

    // Load with one-cycle latency.
    wait_to(R+1);
    din = 16'h4321; update = 1'b1;
    push(R+1, S_DIGS, 0); push(R+2, S_DIGS, 16'h4321);
    wait_to(R+2);
    update = 1'b0;
    // One full rotation aligned to index 0.
    for (int i = 0; i < 16; i++) begin
      push(R+16+i, S_DIG, dig_rot[i/4]);
      push(R+16+i, S_AN, an_rot[i/4]);
    end
    push(R+31, S_EN, 0); push(R+32, S_EN, 1);

    // Hold beats update; dropping hold does not reload.
    wait_to(R+33);
    hold = 1'b1; update = 1'b1; din = 16'h9999;
    wait_to(R+34);
    update = 1'b0;
    push(R+34, S_DIGS, 16'h4321); push(R+35, S_DIGS, 16'h4321);
    wait_to(R+35);
    hold = 1'b0;
    push(R+36, S_DIGS, 16'h4321);
    wait_to(R+36);
    update = 1'b1;
    push(R+37, S_DIGS, 16'h9999);
    wait_to(R+37);
    update = 1'b0;

    // Blink digit 1: dark in its slot while the phase is 0 (cycles R+64..R+95).
    wait_to(R+40);
    mask = 4'b0010;
    for (int c = 48; c < 112; c++) begin
      if (c >= 64 && c < 96 && ((c/4)%4) == 1) push(R+c, S_AN, 4'hF);
      else                                     push(R+c, S_AN, an_rot[(c/4)%4]);
    end
    push(R+63, S_EN, 1); push(R+64, S_EN, 0); push(R+95, S_EN, 0); push(R+96, S_EN, 1);
    wait_to(R+112);
    mask = 4'b0000;

    // Blank: selects off one cycle later, scanning continues.
    wait_to(R+120);
    blank = 1'b1;
    push(R+120, S_AN, 4'b1011);
    for (int c = 121; c <= 124; c++) push(R+c, S_AN, 4'hF);
    push(R+121, S_IDX, 2); push(R+124, S_IDX, 3);
    wait_to(R+124);
    blank = 1'b0;
    push(R+125, S_AN, 4'b0111);

    // Update landing on a scan tick: new value at new index together.
    wait_to(R+131);
    din = 16'hABCD; update = 1'b1;
    push(R+131, S_DIG, 4'h9);
    push(R+132, S_DIG, 32'(digit_slice(abcd, 1)));
    push(R+132, S_IDX, 1); push(R+132, S_AN, 4'b1101);
    wait_to(R+132);
    update = 1'b0;
    push(R+139, S_DIGS, 16'hABCD); push(R+139, S_AN, 4'b1011);

    // Reset mid-scan takes effect immediately.
    wait_to(R+140);
    rst_n = 1'b0;
    push(R+140, S_AN, 4'hF); push(R+140, S_DIG, 0); push(R+140, S_DIGS, 0);
    push(R+140, S_IDX, 0);   push(R+140, S_EN, 0);  push(R+140, S_IDX2, 0);
    wait_to(R+142);
    rst_n = 1'b1;
    r2 = R+142;
    push(r2, S_AN, 4'hF);
    push(r2+1, S_AN, 4'b1110); push(r2+1, S_DIGS, 0); push(r2+1, S_EN, 0);
    push(r2+1, S_IDX2, 1); push(r2+2, S_IDX2, 2); push(r2+3, S_IDX2, 0);

    wait_to(r2+10);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain got=%0d left exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_manager.md
Name: display_scan_manager

Overview:
- Parametrised successor to the clock-display register bank. It latches N_DIGITS values of DIGIT_W bits on an update strobe.
- It time-multiplexes the latched digits onto one shared digit bus with a rotating active-low digit select.
- It adds hold (lap freeze), per-digit blink and global blank.
- It sits between the time-keeping counters and the 7-segment decoder/pad logic, using a single clock domain.

Parameters:
- N_DIGITS, 8, number of digits latched and scanned (2..16).
- DIGIT_W, 4, bits per digit value.
- SCAN_DIV, 1000, clk cycles per scan step (>=1; 1 means step every cycle).
- BLINK_SCANS, 250, full scan rotations per blink-phase toggle (>=1).

Ports:
- clk  in  1  system clock, all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- update_i  in  1  load digits_i into the bank this cycle (ignored while hold_i=1).
- hold_i  in  1  freeze the bank (lap); scanning continues.
- blank_i  in  1  force all digits off.
- blink_mask_i  in  N_DIGITS  bit k=1: digit k blinks.
- digits_i  in  N_DIGITS*DIGIT_W  packed digit values, digit k at [k*DIGIT_W +: DIGIT_W].
- digits_o  out  N_DIGITS*DIGIT_W  current bank contents.
- digit_o  out  DIGIT_W  value of the currently selected digit.
- an_o  out  N_DIGITS  digit select, active low, at most one bit low.
- scan_idx_o  out  $clog2(N_DIGITS)  index of the selected digit.
- display_en_o  out  1  blink phase: 1 = blinking digits visible.

Behaviour:
- Reset (async on rst_n=0, released synchronously to the internal logic):
  - bank = 0.
  - scan_idx = 0.
  - prescaler = 0.
  - blink counter = 0.
  - display_en_o = 0.
  - an_o = all ones.
  - digit_o = 0.
  - digits_o = 0.
- Bank load:
  - If update_i=1 and hold_i=0 at edge t, the bank equals digits_i after edge t. Latency is 1 cycle.
  - If hold_i=1, the bank is unchanged regardless of update_i.
  - When hold_i falls, the bank takes new values on the next update_i. There is no implicit reload.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - scan_tick = 1 for the single cycle in which the count equals SCAN_DIV-1.
- Scan index:
  - On scan_tick, scan_idx increments, wrapping N_DIGITS-1 -> 0.
  - The wrap cycle generates rot_tick.
- Blink:
  - The blink counter counts rot_ticks 0..BLINK_SCANS-1.
  - On its terminal rot_tick, display_en_o toggles and the counter returns to 0.
  - The first toggle (0->1) therefore occurs BLINK_SCANS rotations after reset.
- an_o is registered and updated every cycle from the next-state scan_idx. Bit k is low iff all of the following hold:
  - k == scan_idx.
  - blank_i == 0.
  - Either blink_mask_i[k] == 0 or display_en_o == 1.
- an_o and scan_idx change on the same edge. blank_i and blink_mask_i take effect on an_o 1 cycle after they are applied.
- digit_o = bank[scan_idx], combinational from registers only. There is no combinational input-to-output path.
- Simultaneous events:
  - update and scan_tick on the same edge: both take effect, so digit_o shows the new bank value at the new index.
  - hold_i and update_i both high: hold wins.
- Reset mid-scan returns all state to reset values immediately, with no partial digit pulse beyond the asynchronous assertion.
- Widths:
  - Prescaler width is $clog2(SCAN_DIV) (1 bit minimum).
  - Blink counter width is $clog2(BLINK_SCANS) (1 bit minimum).
  - Index comparisons are zero-extended.
  - N_DIGITS not a power of two is handled by the explicit wrap.

Decomposition:
- Package display_pkg:
  - DIGIT_W default.
  - The AN_OFF convention (active-low select, idle all ones).
  - Function digit_slice(bus, k) for packed-digit access.
  - Typedef digit_t (logic [DIGIT_W-1:0]).
- One sub-module, tick_divider (parameter DIV): wrapping counter with a single-cycle tick output and enable input. It is instantiated twice:
  - prescaler, DIV=SCAN_DIV, enabled always.
  - blink divider, DIV=BLINK_SCANS, enabled by rot_tick.

Test Plan (N_DIGITS=4, DIGIT_W=4, SCAN_DIV=4, BLINK_SCANS=2 unless noted):
- Reset: hold rst_n=0 mid-run -> an_o=4'b1111, digit_o=0, digits_o=0, scan_idx_o=0, display_en_o=0. After release, first an_o=4'b1110 appears 1 cycle later.
- Load: digits_i=16'h4321, update_i=1 for 1 cycle -> digits_o=16'h4321 next cycle. Over 16 cycles, digit_o sequences 1,2,3,4, each held 4 cycles, with an_o cycling 1110,1101,1011,0111.
- Hold: load 16'h4321, set hold_i=1, pulse update_i with 16'h9999 -> digits_o stays 16'h4321. Drop hold_i and pulse update_i -> digits_o=16'h9999.
- Blink: blink_mask_i=4'b0010 ->
  - display_en_o toggles every 32 cycles.
  - While display_en_o=0, an_o never shows 1101 (it is 1111 in that slot).
  - Other digits are unaffected.
- Blank/simultaneity:
  - blank_i=1 -> an_o=1111 one cycle later; scan_idx keeps advancing.
  - update_i coinciding with scan_tick -> digit_o equals the new value at the new index on the same cycle.
- SCAN_DIV=1, N_DIGITS=3: scan_idx_o sequences 0,1,2,0 on consecutive cycles, with no index 3 ever.
